// File: rtl/word_byte_sequencer_if.sv
// word_byte_sequencer_if: word-in / byte-out valid-ready bundle for the byte sequencer
interface word_byte_sequencer_if;
    logic [31:0] in_word;
    logic [3:0]  in_mask;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output in_word, in_mask, in_valid, out_ready,
        input  in_ready, out_byte, out_idx, out_valid, out_last
    );

    modport slave (
        input  in_word, in_mask, in_valid, out_ready,
        output in_ready, out_byte, out_idx, out_valid, out_last
    );
endinterface

// File: rtl/word_byte_sequencer.sv
// word_byte_sequencer: splits masked 32-bit words into a byte stream with valid/ready on both sides
module word_byte_sequencer #(
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    word_byte_sequencer_if.slave   bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       word_cnt
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [31:0]        hold_q, hold_d;
    logic [3:0]         rem_q, rem_d, rem_after;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic [1:0]         out_idx_q, out_idx_d, cur_idx, nxt_idx;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               fire_out, last_fire, accept;

    function automatic logic [1:0] sel_idx(input logic [3:0] r);
        if (MSB_FIRST != 0)
            return r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
        else
            return r[0] ? 2'd0 : r[1] ? 2'd1 : r[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic one_hot(input logic [3:0] r);
        return (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
    endfunction

    assign fire_out     = out_valid_q && bus.out_ready;
    assign last_fire    = fire_out && out_last_q;
    // The final-byte handshake frees the hold register in the same cycle, so a new word can follow without a bubble.
    assign bus.in_ready = (state_q == IDLE) || last_fire;
    assign accept       = bus.in_valid && bus.in_ready;
    assign cur_idx      = sel_idx(rem_q);

    assign bus.out_byte  = out_byte_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q == SEND);
    assign word_cnt      = cnt_q;

    // Next state: retire the shown byte, load a new non-empty word, and pre-compute the next registered outputs.
    always_comb begin
        rem_after   = fire_out ? (rem_q & ~(4'b0001 << cur_idx)) : rem_q;
        hold_d      = (accept && (bus.in_mask != 4'd0)) ? bus.in_word : hold_q;
        rem_d       = (accept && (bus.in_mask != 4'd0)) ? bus.in_mask : rem_after;
        cnt_d       = cnt_q + CNT_W'(last_fire);
        state_d     = (rem_d != 4'd0) ? SEND : IDLE;
        nxt_idx     = sel_idx(rem_d);
        out_valid_d = (state_d == SEND);
        out_idx_d   = (rem_d != 4'd0) ? nxt_idx : out_idx_q;
        out_byte_d  = (rem_d != 4'd0) ? hold_d[{nxt_idx, 3'b000} +: 8] : out_byte_q;
        out_last_d  = one_hot(rem_d);
    end

    // State, datapath and output registers; reset drops any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_byte_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_byte_q  <= out_byte_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule
